rv32_instr_loader_encoder: RTL and testbench

//  Field-level RV32I instruction encoder + instruction-memory loader: inverse of the CPU decode path.

---
 rtl/rv32_enc_pkg.sv | 78 +++++++
 rtl/rv32_field_encoder.sv | 26 ++
 rtl/rv32_instr_loader_encoder.sv | 151 +++++++++++++++
 tb/tb_rv32_instr_loader_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_enc_pkg.sv
// ============================================================================
// Module   : rv32_enc_pkg
// Purpose  : RV32I instruction formats, opcode constants and the field-packing
//            and immediate-range helpers shared by the loader/encoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Immediates are truncated to the field width; unknown formats become a NOP.
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    logic [31:0] word;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = NOP_INSTR;
    endcase
    return word;
  endfunction

  // True when the immediate cannot be represented exactly by the format.
  function automatic logic imm_range_err(
    input logic [2:0]  fmt,
    input logic [31:0] imm
  );
    logic signed [31:0] s_imm;
    logic               bad;
    s_imm = imm;
    bad   = 1'b0;
    case (fmt)
      FMT_R:        bad = 1'b0;
      FMT_I, FMT_S: bad = (s_imm < -32'sd2048) || (s_imm > 32'sd2047);
      FMT_B:        bad = (s_imm < -32'sd4096) || (s_imm > 32'sd4094) || imm[0];
      FMT_U:        bad = (imm[11:0] != 12'd0);
      FMT_J:        bad = (s_imm < -32'sd1048576) || (s_imm > 32'sd1048574) || imm[0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_field_encoder.sv
// ============================================================================
// Module   : rv32_field_encoder
// Purpose  : Purely combinational packing of RV32I fields into a 32-bit word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32_field_encoder
  import rv32_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  assign word = encode_instr(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);

endmodule

`default_nettype wire

// File: rtl/rv32_instr_loader_encoder.sv
// ============================================================================
// Module   : rv32_instr_loader_encoder
// Purpose  : Encodes RV32I field bundles and writes them to instmem from
//            address 0, holding the CPU in reset until the load completes.
//            Optional immediate checking: define RV32_ENC_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32_instr_loader_encoder
  import rv32_enc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_fmt,
  input  logic [6:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [31:0]   in_imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_depth_m1 = (AW+1)'(DEPTH - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [31:0]   w_word;
  logic          w_accept;
  logic          w_last_slot;
  logic          w_start_load;

  rv32_field_encoder u_field_encoder (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (w_word)
  );

  // The count advances on the accept edge, so it already covers the word in flight.
  assign in_ready     = (r_state == ST_LOAD) && (r_count < c_depth);
  assign w_accept     = in_valid && in_ready;
  assign w_last_slot  = (r_count == c_depth_m1);
  assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_accept && (in_last || w_last_slot)) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_mem_we <= w_accept;
      if (w_start_load) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        r_mem_addr  <= r_count[AW-1:0];
        r_mem_wdata <= w_word;
        r_count     <= r_count + 1'b1;
        if (w_last_slot && !in_last) r_overflow <= 1'b1;
      end
    end
  end

`ifdef RV32_ENC_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_err <= 1'b0;
    end else if (w_start_load) begin
      r_err <= 1'b0;
    end else if (w_accept && imm_range_err(in_fmt, in_imm)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign cpu_hold  = (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rv32_instr_loader_encoder.sv
// ============================================================================
// Module   : tb_rv32_instr_loader_encoder
// Purpose  : Directed self-checking bench; u_dut uses DEPTH=256, u_dut4 DEPTH=4.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rv32_instr_loader_encoder;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  logic        a_in_ready, a_mem_we, a_cpu_hold, a_done, a_overflow, a_err;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0]  a_count;

  logic        b_in_ready, b_mem_we, b_cpu_hold, b_done, b_overflow, b_err;
  logic [1:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [2:0]  b_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_instr_loader_encoder #(.DEPTH(256)) u_dut (
    .clk(clk), .res(res), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .cpu_hold(a_cpu_hold),
    .done(a_done), .count(a_count), .overflow(a_overflow), .err(a_err)
  );

  rv32_instr_loader_encoder #(.DEPTH(4)) u_dut4 (
    .clk(clk), .res(res), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .cpu_hold(b_cpu_hold),
    .done(b_done), .count(b_count), .overflow(b_overflow), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    set_word(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #12;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", a_in_ready); end
    checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", a_mem_we); end
    checks++; if (a_mem_addr !== 8'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", a_mem_addr); end
    checks++; if (a_mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", a_mem_wdata); end
    checks++; if (a_cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %0b want 1", a_cpu_hold); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", a_done); end
    checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", a_count); end
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b want 0", a_overflow); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", a_err); end
    tick();
    res = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_start();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", a_in_ready); end
    set_word(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (a_mem_we !== 1'b1) begin errors++; $display("FAIL single_we: got %0b want 1", a_mem_we); end
    checks++; if (a_mem_addr !== 8'd0) begin errors++; $display("FAIL single_addr: got %0d want 0", a_mem_addr); end
    checks++; if (a_mem_wdata !== 32'h002081B3) begin errors++; $display("FAIL single_wdata: got %h want 002081b3", a_mem_wdata); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %0b want 0", a_done); end
    tick();
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL single_done: got %0b want 1", a_done); end
    checks++; if (a_cpu_hold !== 1'b0) begin errors++; $display("FAIL single_hold: got %0b want 0", a_cpu_hold); end
    checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL single_we_off: got %0b want 0", a_mem_we); end
    checks++; if (a_count !== 9'd1) begin errors++; $display("FAIL single_count: got %0d want 1", a_count); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  fm [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    logic [6:0]  op [6] = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33};
    logic [4:0]  rd [6] = '{5'd1, 5'd0, 5'd0, 5'd5, 5'd1, 5'd3};
    logic [4:0]  r1 [6] = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1};
    logic [4:0]  r2 [6] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd2};
    logic [2:0]  f3 [6] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [31:0] im [6] = '{32'd5, 32'd8, 32'd8, 32'h12345000, 32'd16, 32'd0};
    logic [31:0] ex [6] = '{32'h00500093, 32'h0020A423, 32'h00208463,
                            32'h123452B7, 32'h010000EF, 32'h00000013};
    do_start();
    for (int i = 0; i < 6; i++) begin
      set_word(fm[i], op[i], rd[i], r1[i], r2[i], f3[i], 7'd0, im[i]);
      in_valid = 1'b1; in_last = (i == 5);
      tick();
      checks++; if (a_mem_we !== 1'b1) begin errors++; $display("FAIL b2b_we[%0d]: got %0b want 1", i, a_mem_we); end
      checks++; if (a_mem_addr !== 8'(i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, a_mem_addr, i); end
      checks++; if (a_mem_wdata !== ex[i]) begin errors++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, a_mem_wdata, ex[i]); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0b want 1", a_done); end
    checks++; if (a_count !== 9'd6) begin errors++; $display("FAIL b2b_count: got %0d want 6", a_count); end
  endtask

  task automatic test_full();
    logic [31:0] exp_w;
    do_start();
    for (int k = 0; k < 5; k++) begin
      set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
      in_valid = 1'b1; in_last = 1'b0;
      exp_w = (32'(k) << 20) | 32'h00000093;
      checks++; if (b_in_ready !== (k < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %0b want %0b", k, b_in_ready, (k < 4)); end
      tick();
      checks++; if (b_mem_we !== (k < 4)) begin errors++; $display("FAIL full_we[%0d]: got %0b want %0b", k, b_mem_we, (k < 4)); end
      if (k < 4) begin
        checks++; if (b_mem_addr !== 2'(k)) begin errors++; $display("FAIL full_addr[%0d]: got %0d want %0d", k, b_mem_addr, k); end
        checks++; if (b_mem_wdata !== exp_w) begin errors++; $display("FAIL full_wdata[%0d]: got %h want %h", k, b_mem_wdata, exp_w); end
      end
    end
    checks++; if (b_overflow !== 1'b1) begin errors++; $display("FAIL full_ovf: got %0b want 1", b_overflow); end
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b want 1", b_done); end
    checks++; if (b_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", b_count); end
    in_valid = 1'b0;
    tick();
    checks++; if (b_mem_we !== 1'b0) begin errors++; $display("FAIL full_no5th: got %0b want 0", b_mem_we); end
  endtask

  task automatic test_reset_mid();
    res = 1'b0; tick(); res = 1'b1; tick();
    do_start();
    for (int k = 1; k <= 2; k++) begin
      set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
      in_valid = 1'b1; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (a_count !== 9'd2) begin errors++; $display("FAIL mid_count_pre: got %0d want 2", a_count); end
    #2;
    res = 1'b0;
    #1;
    checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %0b want 0", a_mem_we); end
    checks++; if (a_mem_addr !== 8'd0) begin errors++; $display("FAIL mid_addr: got %0d want 0", a_mem_addr); end
    checks++; if (a_mem_wdata !== 32'd0) begin errors++; $display("FAIL mid_wdata: got %h want 0", a_mem_wdata); end
    checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", a_count); end
    checks++; if (a_cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_hold: got %0b want 1", a_cpu_hold); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %0b want 0", a_in_ready); end
    tick();
    res = 1'b1;
    tick();
    do_start();
    set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (a_mem_addr !== 8'd0 || a_mem_we !== 1'b1) begin errors++; $display("FAIL mid_rewrite: got we=%0b addr=%0d want we=1 addr=0", a_mem_we, a_mem_addr); end
    checks++; if (a_mem_wdata !== 32'h00700093) begin errors++; $display("FAIL mid_rewdata: got %h want 00700093", a_mem_wdata); end
    checks++; if (a_count !== 9'd1) begin errors++; $display("FAIL mid_count1: got %0d want 1", a_count); end
    tick();
  endtask

  task automatic test_stall();
    int          n;
    logic        acc;
    logic [31:0] exp_w;
    n = 0;
    do_start();
    for (int i = 0; i < 40; i++) begin
      set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      in_valid = 1'($urandom_range(0, 1)); in_last = 1'b0;
      acc   = in_valid && a_in_ready;
      exp_w = (32'(i) << 20) | 32'h00000093;
      tick();
      checks++; if (a_mem_we !== acc) begin errors++; $display("FAIL stall_we[%0d]: got %0b want %0b", i, a_mem_we, acc); end
      if (acc) begin
        checks++; if (a_mem_addr !== 8'(n)) begin errors++; $display("FAIL stall_addr[%0d]: got %0d want %0d", i, a_mem_addr, n); end
        checks++; if (a_mem_wdata !== exp_w) begin errors++; $display("FAIL stall_wdata[%0d]: got %h want %h", i, a_mem_wdata, exp_w); end
        n++;
      end
    end
    checks++; if (a_count !== 9'(n)) begin errors++; $display("FAIL stall_count: got %0d want %0d", a_count, n); end
    set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd99);
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (a_mem_addr !== 8'(n)) begin errors++; $display("FAIL stall_lastaddr: got %0d want %0d", a_mem_addr, n); end
    tick();
    checks++; if (a_done !== 1'b1 || a_count !== 9'(n + 1)) begin errors++; $display("FAIL stall_end: got done=%0b count=%0d want done=1 count=%0d", a_done, a_count, n + 1); end
  endtask

  task automatic test_imm_check();
    logic exp_err;
`ifdef RV32_ENC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_start();
    set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (a_mem_wdata !== 32'h00000093 || a_mem_we !== 1'b1) begin errors++; $display("FAIL imm_word: got we=%0b %h want we=1 00000093", a_mem_we, a_mem_wdata); end
    checks++; if (a_err !== exp_err) begin errors++; $display("FAIL imm_err: got %0b want %0b", a_err, exp_err); end
    tick();
    checks++; if (a_err !== exp_err) begin errors++; $display("FAIL imm_err_sticky: got %0b want %0b", a_err, exp_err); end
    do_start();
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL imm_err_clear: got %0b want 0", a_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_stall();
    test_imm_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
